// File: rtl/spike_event_encoder_if.sv
// Shared system clock and asynchronous active-low reset for the neural-network blocks.
interface system_if;
    logic clk;
    logic reset;
    modport nn (input clk, input reset);
endinterface

// File: rtl/spike_event_encoder.sv
// Small first-word-fall-through FIFO; head_dat is meaningful whenever empty is low.
// Latency: a push is visible at the head one cycle later.
// Backpressure: the caller must only push while not full, or while popping in the same cycle.
module spike_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
            if (push_vld && !pop_rdy)      count <= count + 1'b1;
            else if (!push_vld && pop_rdy) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
endmodule

// Turns per-column spike edges into (address, timestamp) events via round-robin arbitration.
// Latency: pending at the detecting edge, event visible after the following edge.
// Backpressure: full FIFO stalls grants; spikes colliding with a held pending bit are counted as drops.
module spike_event_encoder #(
    parameter  int NUM_COLS   = 1,
    parameter  int FIFO_DEPTH = 8,
    parameter  int TS_WIDTH   = 16,
    localparam int AW         = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    system_if.nn                sys_if,
    input  logic                spike_input [NUM_COLS],
    output logic                event_valid,
    input  logic                event_ready,
    output logic [AW-1:0]       event_address,
    output logic [TS_WIDTH-1:0] event_timestamp,
    input  logic                drop_clear,
    output logic [15:0]         drop_count,
    output logic                overflow
);
    typedef struct packed {
        logic [AW-1:0]       addr;
        logic [TS_WIDTH-1:0] ts;
    } event_t;

    logic [NUM_COLS-1:0] prev;
    logic [NUM_COLS-1:0] pending;
    logic [NUM_COLS-1:0] rise;
    logic [NUM_COLS-1:0] grant_oh;
    logic [TS_WIDTH-1:0] ts_cnt;
    logic [TS_WIDTH-1:0] ts_cap [NUM_COLS];
    logic [AW-1:0]       rr_ptr;
    logic [AW-1:0]       grant_col;
    logic [AW-1:0]       cand;
    logic                grant_vld;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic [31:0]         n_drop;
    logic [31:0]         drop_sum;
    event_t              push_ev;
    event_t              head;

    assign event_valid = !fifo_empty;
    assign pop         = event_valid && event_ready;

    always_comb begin
        rise = '0;
        for (int c = 0; c < NUM_COLS; c++) rise[c] = spike_input[c] & ~prev[c];
    end

    // A full FIFO can still accept a grant when its head leaves on the same edge.
    always_comb begin
        grant_vld = 1'b0;
        grant_col = '0;
        grant_oh  = '0;
        cand      = '0;
        if (!fifo_full || pop) begin
            for (int k = 0; k < NUM_COLS; k++) begin
                cand = AW'((int'(rr_ptr) + k) % NUM_COLS);
                if (!grant_vld && pending[cand]) begin
                    grant_vld      = 1'b1;
                    grant_col      = cand;
                    grant_oh[cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        n_drop = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (rise[c] && pending[c] && !grant_oh[c]) n_drop = n_drop + 32'd1;
        end
        drop_sum = {16'd0, drop_count} + n_drop;
    end

    always_ff @(posedge sys_if.clk or negedge sys_if.reset) begin
        if (!sys_if.reset) begin
            prev       <= '0;
            pending    <= '0;
            rr_ptr     <= '0;
            ts_cnt     <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
            for (int c = 0; c < NUM_COLS; c++) ts_cap[c] <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            // A spike arriving as its column is granted simply re-arms the slot.
            for (int c = 0; c < NUM_COLS; c++) begin
                prev[c] <= spike_input[c];
                if (rise[c] && (!pending[c] || grant_oh[c])) begin
                    pending[c] <= 1'b1;
                    ts_cap[c]  <= ts_cnt;
                end else if (grant_oh[c]) begin
                    pending[c] <= 1'b0;
                end
            end
            if (grant_vld) rr_ptr <= (int'(grant_col) == NUM_COLS - 1) ? '0 : grant_col + 1'b1;
            if (drop_clear) begin
                drop_count <= '0;
                overflow   <= 1'b0;
            end else if (n_drop != 32'd0) begin
                drop_count <= (drop_sum > 32'h0000_FFFF) ? 16'hFFFF : drop_sum[15:0];
                overflow   <= 1'b1;
            end
        end
    end

    assign push_ev.addr = grant_col;
    assign push_ev.ts   = ts_cap[grant_col];

    spike_event_fifo #(
        .WIDTH ($bits(event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (sys_if.clk),
        .rst_n    (sys_if.reset),
        .push_vld (grant_vld),
        .push_dat (push_ev),
        .pop_rdy  (pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign event_address   = event_valid ? head.addr : '0;
    assign event_timestamp = event_valid ? head.ts   : '0;
endmodule

// File: tb/tb_spike_event_encoder.sv
// Scenario tasks with constant expectations plus a randomized run against a queue-based model.
module tb_spike_event_encoder;
    localparam int N   = 10;
    localparam int D   = 8;
    localparam int TSW = 6;
    localparam int AW  = 4;

    system_if sys_if();

    logic           spike [N];
    logic           ready;
    logic           clr;
    logic           vld;
    logic [AW-1:0]  addr;
    logic [TSW-1:0] ts;
    logic [15:0]    dcnt;
    logic           ovf;

    int vec  = 0;
    int errs = 0;

    spike_event_encoder #(.NUM_COLS(N), .FIFO_DEPTH(D), .TS_WIDTH(TSW)) dut (
        .sys_if          (sys_if),
        .spike_input     (spike),
        .event_valid     (vld),
        .event_ready     (ready),
        .event_address   (addr),
        .event_timestamp (ts),
        .drop_clear      (clr),
        .drop_count      (dcnt),
        .overflow        (ovf)
    );

    initial sys_if.clk = 1'b0;
    always #5 sys_if.clk = ~sys_if.clk;

    // Reference model: events are a queue, pending spikes a flag + timestamp per column.
    typedef struct { int addr; int ts; } ev_t;
    ev_t m_q[$];
    int  m_cnt = 0;
    int  m_rr = 0;
    int  m_drop = 0;
    bit  m_ovf = 0;
    bit  m_prev [N];
    bit  m_pend [N];
    int  m_ts [N];

    always @(posedge sys_if.clk or negedge sys_if.reset) begin
        int g;
        int drops;
        bit pop;
        bit rise [N];
        if (!sys_if.reset) begin
            m_q.delete();
            m_cnt = 0; m_rr = 0; m_drop = 0; m_ovf = 0;
            for (int c = 0; c < N; c++) begin m_prev[c] = 0; m_pend[c] = 0; m_ts[c] = 0; end
        end else begin
            pop = (m_q.size() > 0) && (ready === 1'b1);
            g = -1;
            if (m_q.size() < D || pop)
                for (int k = 0; k < N; k++)
                    if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
            drops = 0;
            for (int c = 0; c < N; c++) begin
                rise[c] = (spike[c] === 1'b1) && !m_prev[c];
                if (rise[c] && m_pend[c] && c != g) drops++;
            end
            if (pop) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back('{addr: g, ts: m_ts[g]});
                m_pend[g] = 0;
                m_rr = (g + 1) % N;
            end
            for (int c = 0; c < N; c++)
                if (rise[c] && !m_pend[c]) begin m_pend[c] = 1; m_ts[c] = m_cnt; end
            if (clr === 1'b1) begin
                m_drop = 0; m_ovf = 0;
            end else if (drops > 0) begin
                m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
                m_ovf = 1;
            end
            m_cnt = (m_cnt + 1) % (1 << TSW);
            for (int c = 0; c < N; c++) m_prev[c] = (spike[c] === 1'b1);
        end
    end

    task automatic set_spikes(input logic [N-1:0] m);
        for (int c = 0; c < N; c++) spike[c] = m[c];
    endtask

    task automatic pulse_reset;
        @(negedge sys_if.clk);
        sys_if.reset = 1'b0;
        set_spikes('0);
        ready = 1'b0;
        clr = 1'b0;
        @(negedge sys_if.clk);
        sys_if.reset = 1'b1;
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 70 && m_cnt != target; i++) @(negedge sys_if.clk);
    endtask

    task automatic test_reset;
        sys_if.reset = 1'b0;
        ready = 1'b0;
        clr = 1'b0;
        set_spikes('0);
        repeat (2) @(negedge sys_if.clk);
        vec++; if (vld !== 1'b0)  begin errs++; $display("FAIL reset_valid: got %b want 0", vld); end
        vec++; if (addr !== '0)   begin errs++; $display("FAIL reset_addr: got %0d want 0", addr); end
        vec++; if (ts !== '0)     begin errs++; $display("FAIL reset_ts: got %0d want 0", ts); end
        vec++; if (dcnt !== '0)   begin errs++; $display("FAIL reset_drop_count: got %0d want 0", dcnt); end
        vec++; if (ovf !== 1'b0)  begin errs++; $display("FAIL reset_overflow: got %b want 0", ovf); end
        sys_if.reset = 1'b1;
    endtask

    task automatic test_single_spike;
        pulse_reset();
        ready = 1'b1;
        wait_cnt(5);
        spike[2] = 1'b1;
        @(negedge sys_if.clk);
        vec++; if (vld !== 1'b0) begin errs++; $display("FAIL single_pending: valid got %b want 0", vld); end
        spike[2] = 1'b0;
        @(negedge sys_if.clk);
        vec++;
        if (vld !== 1'b1 || addr !== 4'd2 || ts !== 6'd5) begin
            errs++; $display("FAIL single_event: got v=%b a=%0d t=%0d want v=1 a=2 t=5", vld, addr, ts);
        end
        @(negedge sys_if.clk);
        vec++; if (vld !== 1'b0) begin errs++; $display("FAIL single_pop: valid got %b want 0", vld); end
    endtask

    task automatic test_round_robin;
        logic [AW-1:0]  got_a [4];
        logic [TSW-1:0] got_t [4];
        int exp_a [4];
        int exp_t [4];
        int n;
        exp_a = '{0, 1, 3, 0};
        exp_t = '{10, 10, 10, 12};
        pulse_reset();
        ready = 1'b1;
        wait_cnt(10);
        spike[0] = 1'b1; spike[1] = 1'b1; spike[3] = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_if.clk);
            if (i == 0) set_spikes('0);
            if (i == 1) spike[0] = 1'b1;
            if (i == 2) spike[0] = 1'b0;
            if (vld === 1'b1 && n < 4) begin got_a[n] = addr; got_t[n] = ts; n++; end
        end
        vec++; if (n != 4) begin errs++; $display("FAIL rr_count: got %0d events want 4", n); end
        for (int k = 0; k < n; k++) begin
            vec++;
            if (got_a[k] !== AW'(exp_a[k]) || got_t[k] !== TSW'(exp_t[k])) begin
                errs++; $display("FAIL rr_event%0d: got a=%0d t=%0d want a=%0d t=%0d", k, got_a[k], got_t[k], exp_a[k], exp_t[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [AW-1:0]  got_a [12];
        logic [TSW-1:0] got_t [12];
        int n;
        pulse_reset();
        set_spikes(10'h1FF);
        @(negedge sys_if.clk);
        set_spikes('0);
        repeat (12) @(negedge sys_if.clk);
        vec++;
        if (vld !== 1'b1 || addr !== 4'd0 || ts !== 6'd0) begin
            errs++; $display("FAIL bp_head: got v=%b a=%0d t=%0d want v=1 a=0 t=0", vld, addr, ts);
        end
        ready = 1'b1;
        n = 0;
        for (int i = 0; i < 14; i++) begin
            if (vld === 1'b1 && n < 12) begin got_a[n] = addr; got_t[n] = ts; n++; end
            @(negedge sys_if.clk);
        end
        vec++; if (n != 9) begin errs++; $display("FAIL bp_count: got %0d events want 9", n); end
        for (int k = 0; k < n && k < 9; k++) begin
            vec++;
            if (got_a[k] !== AW'(k) || got_t[k] !== 6'd0) begin
                errs++; $display("FAIL bp_event%0d: got a=%0d t=%0d want a=%0d t=0", k, got_a[k], got_t[k], k);
            end
        end
        vec++; if (dcnt !== 16'd0) begin errs++; $display("FAIL bp_drops: got %0d want 0", dcnt); end
    endtask

    task automatic test_collision;
        pulse_reset();
        set_spikes(10'h1FD);
        @(negedge sys_if.clk);
        set_spikes('0);
        repeat (10) @(negedge sys_if.clk);
        spike[1] = 1'b1; @(negedge sys_if.clk);
        spike[1] = 1'b0; @(negedge sys_if.clk);
        repeat (3) begin
            spike[1] = 1'b1; @(negedge sys_if.clk);
            spike[1] = 1'b0; @(negedge sys_if.clk);
        end
        vec++;
        if (dcnt !== 16'd3 || ovf !== 1'b1) begin
            errs++; $display("FAIL coll_count: got cnt=%0d ovf=%b want cnt=3 ovf=1", dcnt, ovf);
        end
        vec++;
        if (vld !== 1'b1 || addr !== 4'd0) begin
            errs++; $display("FAIL coll_head_hold: got v=%b a=%0d want v=1 a=0", vld, addr);
        end
        clr = 1'b1; @(negedge sys_if.clk); clr = 1'b0;
        vec++;
        if (dcnt !== 16'd0 || ovf !== 1'b0) begin
            errs++; $display("FAIL coll_clear: got cnt=%0d ovf=%b want 0/0", dcnt, ovf);
        end
        spike[1] = 1'b1; clr = 1'b1; @(negedge sys_if.clk);
        spike[1] = 1'b0; clr = 1'b0;
        vec++;
        if (dcnt !== 16'd0 || ovf !== 1'b0) begin
            errs++; $display("FAIL coll_clear_priority: got cnt=%0d ovf=%b want 0/0", dcnt, ovf);
        end
        @(negedge sys_if.clk);
        set_spikes('1); @(negedge sys_if.clk);
        set_spikes('0); @(negedge sys_if.clk);
        for (int p = 0; p < 6553; p++) begin
            set_spikes('1); @(negedge sys_if.clk);
            set_spikes('0); @(negedge sys_if.clk);
        end
        vec++; if (dcnt !== 16'd65531) begin errs++; $display("FAIL sat_below: got %0d want 65531", dcnt); end
        set_spikes('1); @(negedge sys_if.clk);
        set_spikes('0); @(negedge sys_if.clk);
        vec++;
        if (dcnt !== 16'hFFFF || ovf !== 1'b1) begin
            errs++; $display("FAIL sat_hit: got cnt=%0d ovf=%b want 65535/1", dcnt, ovf);
        end
        set_spikes('1); @(negedge sys_if.clk);
        set_spikes('0); @(negedge sys_if.clk);
        vec++; if (dcnt !== 16'hFFFF) begin errs++; $display("FAIL sat_hold: got %0d want 65535", dcnt); end
    endtask

    task automatic test_wrap;
        logic [AW-1:0]  got_a [4];
        logic [TSW-1:0] got_t [4];
        int n;
        pulse_reset();
        ready = 1'b1;
        wait_cnt(63);
        spike[4] = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_if.clk);
            if (i == 0) spike[4] = 1'b0;
            if (i == 1) spike[5] = 1'b1;
            if (i == 2) spike[5] = 1'b0;
            if (vld === 1'b1 && n < 4) begin got_a[n] = addr; got_t[n] = ts; n++; end
        end
        vec++; if (n != 2) begin errs++; $display("FAIL wrap_count: got %0d events want 2", n); end
        vec++;
        if (got_a[0] !== 4'd4 || got_t[0] !== 6'd63) begin
            errs++; $display("FAIL wrap_first: got a=%0d t=%0d want a=4 t=63", got_a[0], got_t[0]);
        end
        vec++;
        if (got_a[1] !== 4'd5 || got_t[1] !== 6'd1) begin
            errs++; $display("FAIL wrap_second: got a=%0d t=%0d want a=5 t=1", got_a[1], got_t[1]);
        end
    endtask

    task automatic test_reset_mid;
        pulse_reset();
        set_spikes(10'h1F); @(negedge sys_if.clk);
        set_spikes(10'h08); @(negedge sys_if.clk);
        set_spikes(10'h18); @(negedge sys_if.clk);
        set_spikes(10'h08); @(negedge sys_if.clk);
        vec++;
        if (vld !== 1'b1 || addr !== 4'd0 || dcnt !== 16'd1 || ovf !== 1'b1) begin
            errs++; $display("FAIL mid_pre: got v=%b a=%0d cnt=%0d ovf=%b want 1/0/1/1", vld, addr, dcnt, ovf);
        end
        #2 sys_if.reset = 1'b0;
        #1;
        vec++;
        if (vld !== 1'b0 || addr !== '0 || ts !== '0 || dcnt !== '0 || ovf !== 1'b0) begin
            errs++; $display("FAIL mid_async: got v=%b a=%0d t=%0d cnt=%0d ovf=%b want all 0", vld, addr, ts, dcnt, ovf);
        end
        @(negedge sys_if.clk);
        sys_if.reset = 1'b1;
        @(negedge sys_if.clk);
        vec++; if (vld !== 1'b0) begin errs++; $display("FAIL mid_stale: valid got %b want 0", vld); end
        @(negedge sys_if.clk);
        vec++;
        if (vld !== 1'b1 || addr !== 4'd3 || ts !== 6'd0) begin
            errs++; $display("FAIL mid_fresh: got v=%b a=%0d t=%0d want v=1 a=3 t=0", vld, addr, ts);
        end
        set_spikes('0);
        ready = 1'b1;
        repeat (4) @(negedge sys_if.clk);
        vec++; if (vld !== 1'b0) begin errs++; $display("FAIL mid_drained: valid got %b want 0", vld); end
    endtask

    task automatic test_random;
        logic [N-1:0] s;
        pulse_reset();
        s = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) if ($urandom_range(0, 3) == 0) s[c] = ~s[c];
            set_spikes(s);
            ready = ($urandom_range(0, 9) < (((i / 500) % 2 == 1) ? 8 : 3));
            clr = ($urandom_range(0, 63) == 0);
            @(negedge sys_if.clk);
            vec++;
            if (vld !== (m_q.size() != 0)) begin
                errs++; $display("FAIL rand_valid cyc %0d: got %b want %b", i, vld, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                vec++;
                if (addr !== AW'(m_q[0].addr) || ts !== TSW'(m_q[0].ts)) begin
                    errs++; $display("FAIL rand_event cyc %0d: got a=%0d t=%0d want a=%0d t=%0d", i, addr, ts, m_q[0].addr, m_q[0].ts);
                end
            end
            vec++;
            if (dcnt !== 16'(m_drop) || ovf !== m_ovf) begin
                errs++; $display("FAIL rand_drops cyc %0d: got cnt=%0d ovf=%b want cnt=%0d ovf=%b", i, dcnt, ovf, m_drop, m_ovf);
            end
        end
        clr = 1'b0;
        set_spikes('0);
    endtask

    initial begin
        test_reset();
        test_single_spike();
        test_round_robin();
        test_backpressure();
        test_collision();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/spike_event_encoder.md
# spike_event_encoder

Converts per-column neuron spike pulses leaving the neural network into a serialized address-event stream with timestamps, for readout by the testbench/host side. It is the outbound counterpart of the external stimulus path: spikes enter as one bit per column and leave as (address, timestamp) events over a valid/ready handshake. Pending spikes are arbitrated round-robin, buffered in a FIFO, and counted when dropped.

## Interface
- NUM_COLS, 1: number of neuron columns; must be ≥1.
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- TS_WIDTH, 16: timestamp width in bits.
- AW (localparam): address width = max(1, $clog2(NUM_COLS)).

- sys_if.clk  input  1  system clock, all logic on rising edge.
- sys_if.reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- sys_if is connected as system_if.nn. One clock domain; reset is asynchronous and active-low.
- spike_input[NUM_COLS]  input  1 each  neuron spike level, one element per column.
- event_valid  output  1  head event is available.
- event_ready  input  1  consumer accepts the head event.
- event_address  output  AW  column index of the head event.
- event_timestamp  output  TS_WIDTH  capture time of the head event.
- drop_clear  input  1  synchronous pulse; clears drop_count and overflow.
- drop_count  output  16  saturating count of lost spikes.
- overflow  output  1  sticky; set on the first drop.

## Operation
- Edge detect: prev[c] registers spike_input[c] every cycle. A spike is detected when spike_input[c]=1 and prev[c]=0. A held-high input counts as one spike.
- Timestamp counter: free-running, TS_WIDTH bits. Increments every cycle and wraps from 2^TS_WIDTH−1 to 0.
- Capture: on a detected spike, pending[c] is set and ts[c] loads the counter value sampled at that same edge (the pre-increment value).
- Arbiter (round-robin):
  - Each cycle in which the FIFO is not full and any pending bit is set, it grants the first pending column at or after rr_ptr, wrapping modulo NUM_COLS.
  - The grant pushes {c, ts[c]} into the FIFO, clears pending[c], and sets rr_ptr = (c+1) mod NUM_COLS.
  - At most one grant per cycle.
- FIFO full: no grant occurs. Pending bits are held and rr_ptr is unchanged.
- Collision: a new spike on column c while pending[c]=1 and c is not granted that cycle:
  - The new spike is lost; the original pending spike and its timestamp are kept.
  - drop_count increments, saturating at 0xFFFF, and overflow is set.
  - Multiple collisions in one cycle increment drop_count by the number of colliding columns, still saturating.
- Simultaneous grant and new spike on the same column: pending[c] stays set, ts[c] takes the new timestamp, and nothing is dropped.
- drop_clear has priority over increments in the same cycle: the result is count=0 and overflow=0.
- Output: first-word-fall-through FIFO.
  - event_valid = FIFO non-empty; event_address and event_timestamp show the head entry.
  - A pop occurs when event_valid && event_ready. Push and pop in the same cycle are allowed, including when the FIFO is full; occupancy is then unchanged.
- Once event_valid is high, the head entry is held stable until it is popped.

## Timing
- Reset state:
  - event_valid, event_address, event_timestamp, drop_count and overflow are all 0.
  - The FIFO is empty; pending, prev, rr_ptr and the counter are 0.
- Reset is effective immediately on assertion. Mid-operation reset discards all pending spikes and FIFO contents with no partial events.
- After reset deassertion, a spike_input already high is detected at the first clock edge.
- Latency (uncontended, FIFO empty):
  - spike_input rises before edge k; pending is set at edge k.
  - The FIFO write happens at edge k+1, and event_valid is high after edge k+1, with timestamp = counter value at edge k.
- Throughput: one event per cycle in, one per cycle out.
- With N columns spiking at the same edge k, their events are written at edges k+1 … k+N in round-robin order.
- Full FIFO with event_ready=1 and pending set: the pop and the push happen at the same edge.

## Test plan
- Single spike: reset, wait until counter=5, pulse column 2 (NUM_COLS=4) → event_valid after 2 edges, address=2, timestamp=5; with ready=1 it pops and event_valid falls.
- Round-robin: rr_ptr=0, columns 3, 0 and 1 rise together at ts=10 → events in order 0, 1, 3, all with timestamp=10; a following spike on column 0 is granted after column 3.
- Backpressure: ready=0, FIFO_DEPTH=8, 9 spikes on distinct columns → FIFO holds 8 and the 9th stays pending.
  - Raising ready drains 9 events in order with no drops (drop_count=0).
- Collision: hold ready=0 with the FIFO full and column 1 pending, then re-pulse column 1 three times → drop_count=3, overflow=1.
  - drop_clear → 0/0. Saturation check: force 0xFFFF + 1 more drop → count stays 0xFFFF.
- Wrap: TS_WIDTH=4, spike at counter=15 and another after 2 cycles → timestamps 15, then 1.
- Reset mid-operation: FIFO holding 3 events and 2 pending spikes, assert reset → all outputs 0 immediately.
  - After release, no stale events appear; a new spike gets a timestamp counted from 0.
